// File: rtl/gpio_input_conditioner.sv
// Per-bit GPI conditioner: two-flop synchronizer, counter debounce, registered
// rise/fall pulses and a sticky write-1-to-clear edge status with masked irq.
module gpio_input_conditioner #(
  parameter int unsigned WIDTH           = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gpi_raw,
  output logic [WIDTH-1:0] gpi_level,
  output logic [WIDTH-1:0] gpi_rise,
  output logic [WIDTH-1:0] gpi_fall,
  input  logic [WIDTH-1:0] irq_en,
  input  logic [WIDTH-1:0] status_clr,
  output logic [WIDTH-1:0] edge_status,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic [WIDTH-1:0] status_q;
  logic [WIDTH-1:0] status_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Debounce counters, level acceptance, edge pulses and sticky status next-state
  always_comb begin
    stable_d = stable_q;
    rise_d   = {WIDTH{1'b0}};
    fall_d   = {WIDTH{1'b0}};
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = s2_q[i];
        rise_d[i]   = s2_q[i];
        fall_d[i]   = ~s2_q[i];
        cnt_d[i]    = CNT_ZERO;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
    // Set uses the pulse already registered, so it lands one cycle after it and beats a clear
    status_d = rise_q | fall_q | (status_q & ~status_clr);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      s1_q     <= {WIDTH{1'b0}};
      s2_q     <= {WIDTH{1'b0}};
      stable_q <= {WIDTH{1'b0}};
      rise_q   <= {WIDTH{1'b0}};
      fall_q   <= {WIDTH{1'b0}};
      status_q <= {WIDTH{1'b0}};
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      s1_q     <= gpi_raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      status_q <= status_d;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign gpi_level   = stable_q;
  assign gpi_rise    = rise_q;
  assign gpi_fall    = fall_q;
  assign edge_status = status_q;
  assign irq         = |(status_q & irq_en);

endmodule
